// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  localparam int IMEM_WORD_W    = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    FILL  = 3'd5,
    RUN   = 3'd6,
    ERR   = 3'd7
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  import loader_pkg::*;

  logic                   byte_valid_i;
  logic [7:0]             byte_data_i;
  logic                   byte_ready_o;
  logic                   imem_we_o;
  logic [ADDR_W-1:0]      imem_addr_o;
  logic [IMEM_WORD_W-1:0] imem_data_o;

  modport master (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o
  );

  modport slave (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian stream bytes into one instruction word.
module word_assembler
  import loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             data,
  input  logic                   accept,
  input  logic                   clear,
  output logic [IMEM_WORD_W-1:0] word,
  output logic                   last_byte
);

  logic [1:0] lane;

  assign last_byte = accept && (lane == 2'd3);

  // Insert each accepted byte at its lane; lane wraps 3->0 on the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= 2'd0;
      word <= '0;
    end else if (clear) begin
      lane <= 2'd0;
      word <= '0;
    end else if (accept) begin
      word[{lane, 3'b000} +: 8] <= data;
      lane                      <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes the words to
// instruction memory, zero-fills the remainder, then releases the CPU.
//
// state | meaning
// IDLE  | waiting for load_req_i
// HDR0  | expecting word count low byte
// HDR1  | expecting word count high byte, range check
// DATA  | collecting the bytes of the current word
// WRITE | one-cycle write of the assembled word
// FILL  | writing zero words up to the last address
// RUN   | image complete, CPU released
// ERR   | bad word count, stream refused
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_req_i,
  imem_loader_if.master bus,
  output logic          start_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_HDR0  = HDR0;
  localparam logic [2:0] S_HDR1  = HDR1;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_FILL  = FILL;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_ERR   = ERR;

  logic [2:0]             state;
  logic [7:0]             n_lo;
  logic [ADDR_W:0]        n_words;
  logic [ADDR_W-1:0]      addr;
  logic [15:0]            n_hdr;
  logic                   accept;
  logic                   last_byte;
  logic                   last_word;
  logic                   full_depth;
  logic [IMEM_WORD_W-1:0] word;

  assign bus.byte_ready_o = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
  // A byte coinciding with load_req_i is dropped: the session restarts instead.
  assign accept     = bus.byte_valid_i && bus.byte_ready_o && !load_req_i;
  assign n_hdr      = {bus.byte_data_i, n_lo};
  assign last_word  = ({1'b0, addr} == (n_words - (ADDR_W+1)'(1)));
  assign full_depth = (n_words == (ADDR_W+1)'(DEPTH));

  assign bus.imem_we_o   = (state == S_WRITE) || (state == S_FILL);
  assign bus.imem_addr_o = addr;
  assign bus.imem_data_o = (state == S_WRITE) ? word : '0;
  assign start_o         = (state == S_RUN);
  assign err_o           = (state == S_ERR);
  assign busy_o          = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA) ||
                           (state == S_WRITE) || (state == S_FILL);

  word_assembler u_asm (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .data      (bus.byte_data_i),
    .accept    (accept && (state == S_DATA)),
    .clear     (load_req_i),
    .word      (word),
    .last_byte (last_byte)
  );

  // Session sequencing, header capture and word-address counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      n_lo    <= '0;
      n_words <= '0;
      addr    <= '0;
    end else if (load_req_i) begin
      state   <= S_HDR0;
      n_lo    <= '0;
      n_words <= '0;
      addr    <= '0;
    end else begin
      case (state)
        S_HDR0: if (accept) begin
          n_lo  <= bus.byte_data_i;
          state <= S_HDR1;
        end
        S_HDR1: if (accept) begin
          if ((n_hdr == 16'd0) || (n_hdr > 16'(DEPTH))) begin
            state <= S_ERR;
          end else begin
            n_words <= n_hdr[ADDR_W:0];
            addr    <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: if (last_byte) state <= S_WRITE;
        S_WRITE: begin
          if (last_word && full_depth) begin
            state <= S_RUN;
          end else if (last_word) begin
            addr  <= n_words[ADDR_W-1:0];
            state <= S_FILL;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_DATA;
          end
        end
        S_FILL: begin
          if (&addr) state <= S_RUN;
          else       addr  <= addr + 1'b1;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
